// File: rtl/ms_router_rr.sv
// ms_router_rr
//   NUM_MASTERS x NUM_SLAVES request/ack router. Each master address is
//   decoded to a slave by its top SEL_BITS bits; each slave has its own
//   round-robin arbiter and IDLE/GRANT/RESP state machine. Masters that
//   target different slaves proceed concurrently. Addresses that decode
//   past the last slave are answered with an error ack the next cycle.
//   A slave that does not ack within TIMEOUT cycles is abandoned and the
//   master receives an error ack (TIMEOUT = 0 disables this).
//
// Ports
//   clk, rst          clock (rising edge), asynchronous active-high reset
//   m_req/m_we        per-master request (held until m_ack) and write flag
//   m_addr/m_wdata    packed per-master address / write data
//   m_ack/m_err       one-cycle completion pulse and its error flag
//   m_rdata           packed read data, valid with m_ack, 0 on error/write
//   s_req/s_we        per-slave request and forwarded write flag
//   s_addr/s_wdata    packed forwarded address / write data
//   s_ack/s_rdata     per-slave completion pulse and read data
module ms_router_rr #(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 32,
    parameter int NUM_MASTERS = 2,
    parameter int NUM_SLAVES  = 4,
    parameter int SEL_BITS    = 2,
    parameter int TIMEOUT     = 16
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [NUM_MASTERS-1:0]            m_req,
    input  logic [NUM_MASTERS-1:0]            m_we,
    input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] m_addr,
    input  logic [NUM_MASTERS*DATA_WIDTH-1:0] m_wdata,
    output logic [NUM_MASTERS-1:0]            m_ack,
    output logic [NUM_MASTERS-1:0]            m_err,
    output logic [NUM_MASTERS*DATA_WIDTH-1:0] m_rdata,
    output logic [NUM_SLAVES-1:0]             s_req,
    output logic [NUM_SLAVES-1:0]             s_we,
    output logic [NUM_SLAVES*ADDR_WIDTH-1:0]  s_addr,
    output logic [NUM_SLAVES*DATA_WIDTH-1:0]  s_wdata,
    input  logic [NUM_SLAVES-1:0]             s_ack,
    input  logic [NUM_SLAVES*DATA_WIDTH-1:0]  s_rdata
);
    localparam int MW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] TO_LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] GRANT = 2'd1;
    localparam logic [1:0] RESP  = 2'd2;

    logic [NUM_MASTERS-1:0][SEL_BITS-1:0] m_idx;
    logic [NUM_MASTERS-1:0]               m_bad;
    logic [NUM_MASTERS-1:0]               busy;
    logic [NUM_MASTERS-1:0]               avail;
    logic [NUM_MASTERS-1:0]               derr_reg;

    // Per-slave views exported to the master-side logic
    logic [NUM_SLAVES-1:0][NUM_MASTERS-1:0] own;      // slave holds this master (GRANT or RESP)
    logic [NUM_SLAVES-1:0][NUM_MASTERS-1:0] ack_vec;  // slave is acking this master
    logic [NUM_SLAVES-1:0][NUM_MASTERS-1:0] err_vec;
    logic [NUM_SLAVES-1:0][DATA_WIDTH-1:0]  rdata_vec;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_MASTERS; gi++) begin : g_dec
            assign m_idx[gi] = m_addr[gi*ADDR_WIDTH + ADDR_WIDTH - 1 -: SEL_BITS];
            assign m_bad[gi] = (int'(m_idx[gi]) >= NUM_SLAVES);
        end
    endgenerate

    // A master already owned by a slave (including its m_ack cycle) or in its
    // decode-error ack cycle is not eligible, so a held req is never re-issued.
    always_comb begin
        busy = '0;
        for (int s = 0; s < NUM_SLAVES; s++) begin
            busy = busy | own[s];
        end
    end

    assign avail = m_req & ~busy & ~derr_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            derr_reg <= '0;
        end else begin
            derr_reg <= avail & m_bad;
        end
    end

    always_comb begin
        m_ack   = derr_reg;
        m_err   = derr_reg;
        m_rdata = '0;
        for (int s = 0; s < NUM_SLAVES; s++) begin
            m_ack = m_ack | ack_vec[s];
            m_err = m_err | err_vec[s];
            for (int m = 0; m < NUM_MASTERS; m++) begin
                if (ack_vec[s][m]) begin
                    m_rdata[m*DATA_WIDTH +: DATA_WIDTH] = rdata_vec[s];
                end
            end
        end
    end

    generate
        for (gi = 0; gi < NUM_SLAVES; gi++) begin : g_slv
            logic [1:0]            state_reg;
            logic [MW-1:0]         win_reg;
            logic [MW-1:0]         ptr_reg;
            logic [CW-1:0]         cnt_reg;
            logic                  we_reg;
            logic                  err_reg;
            logic [ADDR_WIDTH-1:0] addr_reg;
            logic [DATA_WIDTH-1:0] wdata_reg;
            logic [DATA_WIDTH-1:0] rdata_reg;
            logic [NUM_MASTERS-1:0] cand_req;
            logic [MW-1:0]         pick;
            logic                  found;
            logic [NUM_MASTERS-1:0] win_onehot;

            always_comb begin
                for (int m = 0; m < NUM_MASTERS; m++) begin
                    cand_req[m] = avail[m] && (m_idx[m] == SEL_BITS'(gi));
                end
            end

            // First requester at or after the round-robin pointer
            always_comb begin
                int c;
                c     = 0;
                found = 1'b0;
                pick  = '0;
                for (int off = 0; off < NUM_MASTERS; off++) begin
                    c = (int'(ptr_reg) + off) % NUM_MASTERS;
                    if (!found && cand_req[c]) begin
                        found = 1'b1;
                        pick  = MW'(c);
                    end
                end
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    state_reg <= IDLE;
                    win_reg   <= '0;
                    ptr_reg   <= '0;
                    cnt_reg   <= '0;
                    we_reg    <= 1'b0;
                    err_reg   <= 1'b0;
                    addr_reg  <= '0;
                    wdata_reg <= '0;
                    rdata_reg <= '0;
                end else begin
                    case (state_reg)
                        IDLE: begin
                            if (found) begin
                                state_reg <= GRANT;
                                win_reg   <= pick;
                                we_reg    <= m_we[pick];
                                addr_reg  <= m_addr[int'(pick)*ADDR_WIDTH +: ADDR_WIDTH];
                                wdata_reg <= m_wdata[int'(pick)*DATA_WIDTH +: DATA_WIDTH];
                                cnt_reg   <= '0;
                                err_reg   <= 1'b0;
                            end
                        end
                        GRANT: begin
                            // s_ack wins over a timeout expiring in the same cycle
                            if (s_ack[gi]) begin
                                state_reg <= RESP;
                                err_reg   <= 1'b0;
                                rdata_reg <= we_reg ? '0 : s_rdata[gi*DATA_WIDTH +: DATA_WIDTH];
                            end else if ((TIMEOUT != 0) && (cnt_reg == TO_LAST)) begin
                                state_reg <= RESP;
                                err_reg   <= 1'b1;
                                rdata_reg <= '0;
                            end else begin
                                cnt_reg <= cnt_reg + CW'(1);
                            end
                        end
                        RESP: begin
                            state_reg <= IDLE;
                            ptr_reg   <= (win_reg == MW'(NUM_MASTERS - 1)) ? '0 : win_reg + MW'(1);
                        end
                        default: state_reg <= IDLE;
                    endcase
                end
            end

            assign win_onehot     = NUM_MASTERS'(1) << win_reg;
            assign own[gi]        = (state_reg != IDLE) ? win_onehot : '0;
            assign ack_vec[gi]    = (state_reg == RESP) ? win_onehot : '0;
            assign err_vec[gi]    = ((state_reg == RESP) && err_reg) ? win_onehot : '0;
            assign rdata_vec[gi]  = rdata_reg;

            assign s_req[gi]                              = (state_reg == GRANT);
            assign s_we[gi]                               = we_reg;
            assign s_addr[gi*ADDR_WIDTH +: ADDR_WIDTH]    = addr_reg;
            assign s_wdata[gi*DATA_WIDTH +: DATA_WIDTH]   = wdata_reg;
        end
    endgenerate
endmodule

// File: tb/tb_ms_router_rr.sv
// Testbench for ms_router_rr: 2 masters, 3 slaves (slave index 3 decodes
// as an error), TIMEOUT 16. Slaves are modelled with a programmable ack
// delay counted from the first cycle s_req is high (255 = never ack).
module tb_ms_router_rr;
    localparam int DW = 32;
    localparam int AW = 32;
    localparam int NM = 2;
    localparam int NS = 3;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [NM-1:0]     m_req = '0;
    logic [NM-1:0]     m_we = '0;
    logic [NM*AW-1:0]  m_addr = '0;
    logic [NM*DW-1:0]  m_wdata = '0;
    logic [NM-1:0]     m_ack;
    logic [NM-1:0]     m_err;
    logic [NM*DW-1:0]  m_rdata;
    logic [NS-1:0]     s_req;
    logic [NS-1:0]     s_we;
    logic [NS*AW-1:0]  s_addr;
    logic [NS*DW-1:0]  s_wdata;
    logic [NS-1:0]     s_ack = '0;
    logic [NS*DW-1:0]  s_rdata = '0;

    ms_router_rr #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_MASTERS(NM),
        .NUM_SLAVES(NS), .SEL_BITS(2), .TIMEOUT(16)
    ) dut (
        .clk(clk), .rst(rst),
        .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_ack(m_ack), .m_err(m_err), .m_rdata(m_rdata),
        .s_req(s_req), .s_we(s_we), .s_addr(s_addr), .s_wdata(s_wdata),
        .s_ack(s_ack), .s_rdata(s_rdata)
    );

    always #5 clk = ~clk;

    // Slave models
    int          dly[NS];
    logic [31:0] sval[NS];
    int          scnt[NS];

    always @(negedge clk) begin
        for (int s = 0; s < NS; s++) begin
            if (s_ack[s]) begin
                s_ack[s] = 1'b0;
                scnt[s]  = 0;
            end else if (s_req[s]) begin
                if (scnt[s] == dly[s]) begin
                    s_ack[s] = 1'b1;
                    s_rdata[s*DW +: DW] = sval[s];
                end else begin
                    scnt[s]++;
                end
            end else begin
                scnt[s] = 0;
            end
        end
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic set_req(input int m, input logic we, input logic [31:0] a, input logic [31:0] d);
        m_req[m] = 1'b1;
        m_we[m]  = we;
        m_addr[m*AW +: AW]  = a;
        m_wdata[m*DW +: DW] = d;
    endtask

    // Results of the last run_masters call
    int          lat[NM];
    logic        errs[NM];
    logic [31:0] rds[NM];
    logic [NS-1:0] first_sreq;
    logic [31:0] first_addr;
    logic        first_we;
    logic [31:0] first_wdata;
    int          sreq_cyc;

    // Requests must already be driven (after a negedge). Cycle t=1 is the one
    // following the edge that samples them. Each master's req is dropped in
    // the cycle its m_ack is seen.
    task automatic run_masters(input logic [NM-1:0] mask, input int sl);
        logic [NM-1:0] pend;
        pend = mask;
        sreq_cyc = 0;
        first_addr = '0; first_we = 1'b0; first_wdata = '0;
        for (int m = 0; m < NM; m++) begin
            lat[m] = -1; errs[m] = 1'b0; rds[m] = '0;
        end
        for (int t = 1; t <= 40 && pend != '0; t++) begin
            @(posedge clk); #1;
            if (t == 1) begin
                first_sreq = s_req;
                if (sl >= 0) begin
                    first_addr  = s_addr[sl*AW +: AW];
                    first_we    = s_we[sl];
                    first_wdata = s_wdata[sl*DW +: DW];
                end
            end
            if (sl >= 0 && s_req[sl]) sreq_cyc++;
            for (int m = 0; m < NM; m++) begin
                if (pend[m] && m_ack[m]) begin
                    lat[m]  = t;
                    errs[m] = m_err[m];
                    rds[m]  = m_rdata[m*DW +: DW];
                    pend[m] = 1'b0;
                    m_req[m] = 1'b0;
                end
            end
        end
        @(posedge clk); #1;
        chk("ack_one_cycle", 64'(m_ack & mask), 64'd0);
    endtask

    typedef struct {
        int          m;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          sl;
        int          d;
        logic [31:0] sv;
        int          exp_lat;
        logic        exp_err;
        logic [31:0] exp_rd;
        int          exp_sreq;
    } vec_t;

    vec_t vecs[11];

    initial begin
        vecs[0]  = '{0, 1'b0, 32'h4000_0010, 32'h0,          1,   2, 32'hDEAD_BEEF,  4, 1'b0, 32'hDEAD_BEEF,  3};
        vecs[1]  = '{1, 1'b1, 32'h8000_0004, 32'h1234_5678,  2,   0, 32'hAAAA_5555,  2, 1'b0, 32'h0,          1};
        vecs[2]  = '{0, 1'b0, 32'h0000_0100, 32'h0,          0,   5, 32'h0BAD_F00D,  7, 1'b0, 32'h0BAD_F00D,  6};
        vecs[3]  = '{1, 1'b0, 32'h7FFF_FFFC, 32'h0,          1,   1, 32'hCAFE_BABE,  3, 1'b0, 32'hCAFE_BABE,  2};
        vecs[4]  = '{0, 1'b0, 32'hC000_0000, 32'h0,         -1,   0, 32'h0,          1, 1'b1, 32'h0,          0};
        vecs[5]  = '{1, 1'b1, 32'hFFFF_FFF0, 32'h5A5A_5A5A, -1,   0, 32'h0,          1, 1'b1, 32'h0,          0};
        vecs[6]  = '{0, 1'b0, 32'h8000_0000, 32'h0,          2, 255, 32'h5555_5555, 17, 1'b1, 32'h0,         16};
        vecs[7]  = '{1, 1'b0, 32'h8000_0040, 32'h0,          2,   3, 32'h600D_CAFE,  5, 1'b0, 32'h600D_CAFE,  4};
        vecs[8]  = '{1, 1'b1, 32'h0000_0008, 32'h0F0F_0000,  0, 255, 32'h0,         17, 1'b1, 32'h0,         16};
        // ack lands in the very cycle the timeout would expire: success
        vecs[9]  = '{0, 1'b0, 32'h4000_0100, 32'h0,          1,  15, 32'h1357_2468, 17, 1'b0, 32'h1357_2468, 16};
        vecs[10] = '{0, 1'b1, 32'h4000_0200, 32'hA5A5_0000,  1,  15, 32'hFFFF_FFFF, 17, 1'b0, 32'h0,         16};

        for (int s = 0; s < NS; s++) begin
            dly[s] = 2; sval[s] = '0; scnt[s] = 0;
        end

        // ---- Reset held 3 cycles with both masters requesting ----
        set_req(0, 1'b0, 32'h4000_0000, 32'h0);
        set_req(1, 1'b0, 32'h8000_0000, 32'h0);
        sval[1] = 32'h1111_0001; sval[2] = 32'h2222_0002;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            chk("rst_ctrl_out", 64'({m_ack, m_err, s_req, s_we}), 64'd0);
            chk("rst_data_out", 64'((|m_rdata) | (|s_addr) | (|s_wdata)), 64'd0);
        end
        @(negedge clk); rst = 1'b0;
        #1 chk("rst_release_sreq", 64'(s_req), 64'd0);
        run_masters(2'b11, -1);
        chk("rst_first_sreq", 64'(first_sreq), 64'b110);
        chk("rst_m0_lat", 64'(lat[0]), 64'd4);
        chk("rst_m1_lat", 64'(lat[1]), 64'd4);
        chk("rst_m0_rdata", 64'(rds[0]), 64'h1111_0001);
        chk("rst_m1_rdata", 64'(rds[1]), 64'h2222_0002);
        $display("[TB] reset: lat0=%0d lat1=%0d", lat[0], lat[1]);

        // ---- Contention on slave 2 (pointer is 0 after M1 was last served) ----
        @(negedge clk);
        dly[2] = 2;
        set_req(0, 1'b1, 32'h8000_0000, 32'h1111_1111);
        set_req(1, 1'b1, 32'h8000_0008, 32'h2222_2222);
        run_masters(2'b11, 2);
        chk("cont1_first_addr", 64'(first_addr), 64'h8000_0000);
        chk("cont1_m0_lat", 64'(lat[0]), 64'd4);
        chk("cont1_m1_lat", 64'(lat[1]), 64'd9);
        chk("cont1_err", 64'({errs[0], errs[1]}), 64'd0);
        chk("cont1_rdata", 64'(rds[0] | rds[1]), 64'd0);
        $display("[TB] contention1: lat0=%0d lat1=%0d", lat[0], lat[1]);

        // A lone M0 transfer leaves slave 2's pointer at master 1
        @(negedge clk);
        set_req(0, 1'b1, 32'h8000_0010, 32'h3333_3333);
        run_masters(2'b01, 2);
        chk("mid_m0_lat", 64'(lat[0]), 64'd4);

        @(negedge clk);
        set_req(0, 1'b1, 32'h8000_0000, 32'h1111_1111);
        set_req(1, 1'b1, 32'h8000_0008, 32'h2222_2222);
        run_masters(2'b11, 2);
        chk("cont2_first_addr", 64'(first_addr), 64'h8000_0008);
        chk("cont2_first_wdata", 64'(first_wdata), 64'h2222_2222);
        chk("cont2_m1_lat", 64'(lat[1]), 64'd4);
        chk("cont2_m0_lat", 64'(lat[0]), 64'd9);
        $display("[TB] contention2: lat0=%0d lat1=%0d", lat[0], lat[1]);

        // ---- Parallel: M0 -> slave 0, M1 -> slave 2 ----
        @(negedge clk);
        dly[0] = 2; sval[0] = 32'hA0A0_A0A0;
        dly[2] = 4; sval[2] = 32'hB2B2_B2B2;
        set_req(0, 1'b0, 32'h0000_0020, 32'h0);
        set_req(1, 1'b0, 32'h8000_0030, 32'h0);
        run_masters(2'b11, -1);
        chk("par_first_sreq", 64'(first_sreq), 64'b101);
        chk("par_m0_lat", 64'(lat[0]), 64'd4);
        chk("par_m1_lat", 64'(lat[1]), 64'd6);
        chk("par_m0_rdata", 64'(rds[0]), 64'hA0A0_A0A0);
        chk("par_m1_rdata", 64'(rds[1]), 64'hB2B2_B2B2);
        $display("[TB] parallel: lat0=%0d lat1=%0d", lat[0], lat[1]);

        // ---- Single-transaction vector table ----
        for (int i = 0; i < 11; i++) begin
            @(negedge clk);
            if (vecs[i].sl >= 0) begin
                dly[vecs[i].sl]  = vecs[i].d;
                sval[vecs[i].sl] = vecs[i].sv;
            end
            set_req(vecs[i].m, vecs[i].we, vecs[i].addr, vecs[i].wdata);
            run_masters(NM'(1) << vecs[i].m, vecs[i].sl);
            chk($sformatf("v%0d_sreq1", i), 64'(first_sreq),
                (vecs[i].sl >= 0) ? (64'd1 << vecs[i].sl) : 64'd0);
            if (vecs[i].sl >= 0) begin
                chk($sformatf("v%0d_saddr", i), 64'(first_addr), 64'(vecs[i].addr));
                chk($sformatf("v%0d_swe", i), 64'(first_we), 64'(vecs[i].we));
                if (vecs[i].we)
                    chk($sformatf("v%0d_swdata", i), 64'(first_wdata), 64'(vecs[i].wdata));
            end
            chk($sformatf("v%0d_lat", i), 64'(lat[vecs[i].m]), 64'(vecs[i].exp_lat));
            chk($sformatf("v%0d_err", i), 64'(errs[vecs[i].m]), 64'(vecs[i].exp_err));
            chk($sformatf("v%0d_rdata", i), 64'(rds[vecs[i].m]), 64'(vecs[i].exp_rd));
            chk($sformatf("v%0d_sreq_cycles", i), 64'(sreq_cyc), 64'(vecs[i].exp_sreq));
            $display("[TB] vec %0d: m%0d %s addr=%h lat=%0d err=%0b rdata=%h sreq_cycles=%0d",
                     i, vecs[i].m, vecs[i].we ? "W" : "R", vecs[i].addr,
                     lat[vecs[i].m], errs[vecs[i].m], rds[vecs[i].m], sreq_cyc);
        end

        // ---- Asynchronous reset in the middle of GRANT ----
        @(negedge clk);
        dly[1] = 255;
        set_req(0, 1'b0, 32'h4000_0000, 32'h0);
        @(posedge clk); #1;
        chk("arst_sreq_before", 64'(s_req), 64'b010);
        repeat (2) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        chk("arst_sreq_drop", 64'(s_req), 64'd0);
        chk("arst_no_ack", 64'(m_ack), 64'd0);
        @(negedge clk); m_req = '0;
        @(posedge clk); #1;
        chk("arst_held", 64'({m_ack, s_req}), 64'd0);
        @(negedge clk); rst = 1'b0;
        $display("[TB] async reset mid-grant: s_req=%b m_ack=%b", s_req, m_ack);

        // Router serves normally after the abort
        @(negedge clk);
        dly[1] = 2; sval[1] = 32'h0F0F_0F0F;
        set_req(0, 1'b0, 32'h4000_0000, 32'h0);
        run_masters(2'b01, 1);
        chk("post_arst_lat", 64'(lat[0]), 64'd4);
        chk("post_arst_rdata", 64'(rds[0]), 64'h0F0F_0F0F);
        $display("[TB] post-reset read: lat=%0d rdata=%h", lat[0], rds[0]);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
